// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Speculative store queue between the core's store path and the data memory
// write port. The core issues stores into the queue. `store_retire` marks them
// committed in program order, and `recover` discards every store that is not
// yet committed. Committed stores drain in order through a valid/ready port, so
// memory only ever sees non-speculative writes.
//
// The entries form a circular queue indexed by three pointers. Each pointer
// carries one extra wrap bit, so that full and empty can be told apart:
//   head : oldest entry (next to drain)
//   cmt  : first uncommitted entry
//   tail : next free entry
// The ordering head <= cmt <= tail holds modulo the wrap bit.
//
// Build options:
//   STORE_BUFFER_FWD_EN  when defined, a combinational store-to-load forwarding
//                        lookup is included. It returns the youngest entry whose
//                        address and size both match exactly. When undefined,
//                        fwd_hit and fwd_data are tied to 0.
//   COMMIT_WIDTH         default for the COMMIT_WIDTH parameter (2 if unset).
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   enq_*               store issued by the core (addr, data, size)
//   sb_full, sb_empty   occupancy status (combinational)
//   store_retire        one bit per store retiring this cycle
//   recover             flush of all uncommitted entries
//   sb2mem_*            write request towards memory (valid/addr/data/size)
//   mem2sb_ready        memory accepts the current request
//   fwd_addr, fwd_size  load lookup key
//   fwd_hit, fwd_data   forwarding result
// -----------------------------------------------------------------------------

package store_buffer_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } mem_size_t;
endpackage

`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 2
`endif

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = `COMMIT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enq_valid,
    input  logic [31:0]             enq_addr,
    input  logic [63:0]             enq_data,
    input  mem_size_t               enq_size,
    output logic                    sb_full,
    input  logic [COMMIT_WIDTH-1:0] store_retire,
    input  logic                    recover,
    output logic                    sb2mem_valid,
    output logic [31:0]             sb2mem_addr,
    output logic [63:0]             sb2mem_data,
    output mem_size_t               sb2mem_size,
    input  logic                    mem2sb_ready,
    output logic                    sb_empty,
    input  logic [31:0]             fwd_addr,
    input  mem_size_t               fwd_size,
    output logic                    fwd_hit,
    output logic [63:0]             fwd_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    // Entry storage. The drain port and the forwarding lookup both read the
    // entries combinationally, so this is register/distributed storage and not
    // a block RAM. The entries are never reset: the pointers alone define
    // which entries are valid.
    logic [31:0] addr_mem [DEPTH];
    logic [63:0] data_mem [DEPTH];
    mem_size_t   size_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] cmt_reg,  cmt_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] retire_cnt;
    logic             enq_fire;
    logic             drain_fire;

    assign count    = tail_reg - head_reg;
    assign sb_full  = (count == DEPTH_P);
    assign sb_empty = (count == '0);

    assign sb2mem_valid = (head_reg != cmt_reg);
    assign sb2mem_addr  = addr_mem[head_reg[IDX_W-1:0]];
    assign sb2mem_data  = data_mem[head_reg[IDX_W-1:0]];
    assign sb2mem_size  = size_mem[head_reg[IDX_W-1:0]];

    // A recover in the same cycle drops the incoming store.
    assign enq_fire   = enq_valid && !sb_full && !recover;
    assign drain_fire = sb2mem_valid && mem2sb_ready;

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            retire_cnt = retire_cnt + PTR_W'(store_retire[i]);
        end
    end

    always_comb begin
        head_next = head_reg + PTR_W'(drain_fire);
        cmt_next  = cmt_reg + retire_cnt;
        tail_next = tail_reg + PTR_W'(enq_fire);
        // Truncate to the committed boundary after this cycle's retirements,
        // so stores retiring alongside the flush survive it.
        if (recover) begin
            tail_next = cmt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            cmt_reg  <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            cmt_reg  <= cmt_next;
            tail_reg <= tail_next;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            addr_mem[tail_reg[IDX_W-1:0]] <= enq_addr;
            data_mem[tail_reg[IDX_W-1:0]] <= enq_data;
            size_mem[tail_reg[IDX_W-1:0]] <= enq_size;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // The lookup works by age offset from head. Offset gi holds a live entry
    // when gi < count. Larger offsets are younger, so the last match found in
    // the priority loop is the youngest matching store.
    logic [DEPTH-1:0] fwd_match;
    logic [63:0]      fwd_cand [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            logic [IDX_W-1:0] slot;
            assign slot = head_reg[IDX_W-1:0] + IDX_W'(gi);
            assign fwd_match[gi] = (PTR_W'(gi) < count) &&
                                   (addr_mem[slot] == fwd_addr) &&
                                   (size_mem[slot] == fwd_size);
            assign fwd_cand[gi] = data_mem[slot];
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = fwd_cand[i];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr, fwd_size};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

    // Usage rules the core must respect.
    a_no_enq_when_full : assert property (@(posedge clock) disable iff (reset)
        !(enq_valid && sb_full));
    a_retire_in_range  : assert property (@(posedge clock) disable iff (reset)
        retire_cnt <= (tail_reg - cmt_reg));

endmodule

// File: tb/tb_store_buffer.sv
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 2
`endif

module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = `COMMIT_WIDTH;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        mem_size_t   size;
    } entry_t;

    // Reference model: program-ordered list of stores still held by the
    // buffer, plus how many of the oldest of them are committed.
    entry_t q[$];
    int     ncmt;

    int checks;
    int errors;
    int dut_writes;

    logic            clock;
    logic            reset;
    logic            enq_valid;
    logic [31:0]     enq_addr;
    logic [63:0]     enq_data;
    mem_size_t       enq_size;
    logic            sb_full;
    logic [CW-1:0]   store_retire;
    logic            recover;
    logic            sb2mem_valid;
    logic [31:0]     sb2mem_addr;
    logic [63:0]     sb2mem_data;
    mem_size_t       sb2mem_size;
    logic            mem2sb_ready;
    logic            sb_empty;
    logic [31:0]     fwd_addr;
    mem_size_t       fwd_size;
    logic            fwd_hit;
    logic [63:0]     fwd_data;

    store_buffer #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_addr     (enq_addr),
        .enq_data     (enq_data),
        .enq_size     (enq_size),
        .sb_full      (sb_full),
        .store_retire (store_retire),
        .recover      (recover),
        .sb2mem_valid (sb2mem_valid),
        .sb2mem_addr  (sb2mem_addr),
        .sb2mem_data  (sb2mem_data),
        .sb2mem_size  (sb2mem_size),
        .mem2sb_ready (mem2sb_ready),
        .sb_empty     (sb_empty),
        .fwd_addr     (fwd_addr),
        .fwd_size     (fwd_size),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] make_pattern(input int rn);
        logic [CW-1:0] p;
        int placed;
        int b;
        p = '0;
        placed = 0;
        while (placed < rn) begin
            b = $urandom_range(CW - 1, 0);
            if (!p[b]) begin
                p[b] = 1'b1;
                placed++;
            end
        end
        return p;
    endfunction

    function automatic mem_size_t rand_size();
        return mem_size_t'($urandom_range(3, 0));
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h200 + 32'($urandom_range(3, 0)) * 8;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        enq_valid    = 1'b0;
        store_retire = '0;
        recover      = 1'b0;
        mem2sb_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        ncmt = 0;
    endtask

    // One clock cycle: drive the inputs, compare the DUT against the model
    // state, then advance the model by the rules of the queue. Illegal requests
    // (enqueue when full, retiring more stores than are uncommitted) are
    // clipped here, so callers may be loose.
    task automatic step(input bit e, input logic [31:0] a, input logic [63:0] d,
                        input mem_size_t s, input int rn_req, input bit rc,
                        input bit rdy, input logic [31:0] fa, input mem_size_t fs);
        int  rn;
        bit  en;
        bit  exp_hit;
        logic [63:0] exp_fd;
        en = e && (q.size() < DEPTH);
        rn = rn_req;
        if (rn > CW) rn = CW;
        if (rn > q.size() - ncmt) rn = q.size() - ncmt;
        @(negedge clock);
        enq_valid    = en;
        enq_addr     = a;
        enq_data     = d;
        enq_size     = s;
        store_retire = make_pattern(rn);
        recover      = rc;
        mem2sb_ready = rdy;
        fwd_addr     = fa;
        fwd_size     = fs;
        #1;
        check("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
        check("sb_full", 64'(sb_full), 64'(q.size() == DEPTH));
        check("sb2mem_valid", 64'(sb2mem_valid), 64'(ncmt > 0));
        if (ncmt > 0) begin
            check("sb2mem_addr", 64'(sb2mem_addr), 64'(q[0].addr));
            check("sb2mem_data", sb2mem_data, q[0].data);
            check("sb2mem_size", 64'(sb2mem_size), 64'(q[0].size));
        end
`ifdef STORE_BUFFER_FWD_EN
        exp_hit = 1'b0;
        exp_fd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == fa && q[i].size == fs) begin
                exp_hit = 1'b1;
                exp_fd  = q[i].data;
                break;
            end
        end
        check("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
        if (exp_hit) check("fwd_data", fwd_data, exp_fd);
`else
        exp_hit = 1'b0;
        exp_fd  = '0;
        check("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
        check("fwd_data", fwd_data, exp_fd);
`endif
        if (sb2mem_valid && rdy) begin
            dut_writes++;
            $display("write %0d: addr=0x%0h data=0x%0h size=%0d",
                     dut_writes, sb2mem_addr, sb2mem_data, sb2mem_size);
        end
        @(posedge clock);
        if (ncmt > 0 && rdy) begin
            q.delete(0);
            ncmt--;
        end
        ncmt += rn;
        if (rc) begin
            while (q.size() > ncmt) q.delete(q.size() - 1);
        end else if (en) begin
            q.push_back('{addr: a, data: d, size: s});
        end
    endtask

    task automatic idle(input int rn, input bit rdy);
        step(1'b0, 32'h0, 64'h0, SIZE_BYTE, rn, 1'b0, rdy, rand_addr(), rand_size());
    endtask

    task automatic enq(input logic [31:0] a, input logic [63:0] d, input mem_size_t s,
                       input int rn, input bit rdy);
        step(1'b1, a, d, s, rn, 1'b0, rdy, rand_addr(), rand_size());
    endtask

    // Commits and drains everything that is left, within a bounded budget.
    task automatic drain_all(input string tag);
        int budget;
        budget = 200;
        while (q.size() > 0 && budget > 0) begin
            idle(CW, 1'b1);
            budget--;
        end
        check(tag, 64'(q.size() == 0 && budget > 0), 64'(1));
    endtask

    initial begin
        int w0;
        int enq_cnt;
        checks       = 0;
        errors       = 0;
        dut_writes   = 0;
        ncmt         = 0;
        reset        = 1'b1;
        enq_valid    = 1'b0;
        enq_addr     = '0;
        enq_data     = '0;
        enq_size     = SIZE_BYTE;
        store_retire = '0;
        recover      = 1'b0;
        mem2sb_ready = 1'b0;
        fwd_addr     = '0;
        fwd_size     = SIZE_BYTE;

        do_reset();
        idle(0, 1'b0);

        // Single store: enqueue, retire, and drain on the next cycle.
        w0 = dut_writes;
        enq(32'h100, 64'hAA, SIZE_WORD, 0, 1'b1);
        idle(1, 1'b1);
        idle(0, 1'b1);
        idle(0, 1'b1);
        check("t1_writes", 64'(dut_writes - w0), 64'(1));

        // Reset while committed entries are waiting discards them.
        enq(32'h108, 64'h1, SIZE_DWORD, 0, 1'b0);
        enq(32'h110, 64'h2, SIZE_DWORD, 1, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(0, 1'b1);

        // Fill to full. A ninth request is clipped and must not apply.
        for (int i = 0; i < DEPTH; i++) enq(32'h300 + 32'(i) * 4, 64'(i), SIZE_WORD, 0, 1'b0);
        enq(32'h400, 64'hDEAD, SIZE_WORD, 0, 1'b0);
        idle(0, 1'b0);
        do_reset();

        // Recover drops uncommitted stores while committed ones still drain.
        w0 = dut_writes;
        for (int i = 0; i < 4; i++) enq(32'h500 + 32'(i) * 8, 64'h50 + 64'(i), SIZE_DWORD, 0, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 32'h5F0, 64'hBAD, SIZE_DWORD, 0, 1'b1, 1'b0, rand_addr(), rand_size());
        for (int i = 0; i < 4; i++) idle(0, 1'b1);
        check("t3_writes", 64'(dut_writes - w0), 64'(2));

        // Back-pressure: the payload holds while ready stays low.
        enq(32'h600, 64'h66, SIZE_HALF, 0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 5; i++) idle(0, 1'b0);
        w0 = dut_writes;
        idle(0, 1'b1);
        idle(0, 1'b0);
        check("t4_writes", 64'(dut_writes - w0), 64'(1));

        // Twenty stores with toggling ready, wrapping the pointers.
        w0 = dut_writes;
        enq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() < DEPTH) enq_cnt++;
            enq(32'h700 + 32'(i) * 4, 64'h7000 + 64'(i), SIZE_WORD, 1, i[0]);
        end
        drain_all("t5_drain");
        check("t5_writes", 64'(dut_writes - w0), 64'(enq_cnt));

`ifdef STORE_BUFFER_FWD_EN
        // Youngest exact match forwards; a size mismatch does not.
        enq(32'h200, 64'h11, SIZE_DWORD, 0, 1'b0);
        enq(32'h200, 64'h22, SIZE_DWORD, 0, 1'b0);
        step(1'b0, 32'h0, 64'h0, SIZE_BYTE, 0, 1'b0, 1'b0, 32'h200, SIZE_DWORD);
        step(1'b0, 32'h0, 64'h0, SIZE_BYTE, 0, 1'b0, 1'b0, 32'h200, SIZE_BYTE);
        drain_all("t6_drain");
`endif

        // Randomised mix of all operations.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99, 0) < 70, rand_addr(), {$urandom(), $urandom()},
                 rand_size(), $urandom_range(CW, 0), $urandom_range(15, 0) == 0,
                 $urandom_range(1, 0) == 1, rand_addr(), rand_size());
        end
        drain_all("final_drain");
        idle(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
